// File: rtl/hard_reset_receiver_pkg.sv
// ---------------------------------------------------------------------------
// hr_pkg
// Shared definitions for the USB-PD TCPC hard-reset receive path:
// one-hot FSM state encoding, ALERT and RECEIVE_DETECT bit positions,
// RX_BUF_FRAME_TYPE codes and the default policy-engine completion budget.
// Ports: none (package).
// ---------------------------------------------------------------------------
package hr_pkg;

  typedef enum logic [5:0] {
    WAIT_FOR_HR      = 6'b000001,
    RESET_LAYER      = 6'b000010,
    INDICATE         = 6'b000100,
    WAIT_PE_COMPLETE = 6'b001000,
    TIMEOUT          = 6'b010000,
    REPORT           = 6'b100000
  } hr_state_t;

  localparam int ALERT_RX_HARD_RESET = 3;
  localparam int ALERT_FAULT         = 9;

  // Only these ALERT bits are owned by this block; all others stay 0.
  localparam logic [15:0] ALERT_USED_MASK = 16'h0208;

  localparam int RD_HARD_RESET_EN  = 5;
  localparam int RD_CABLE_RESET_EN = 6;

  localparam logic [2:0] FRAME_NONE        = 3'b000;
  localparam logic [2:0] FRAME_HARD_RESET  = 3'b101;
  localparam logic [2:0] FRAME_CABLE_RESET = 3'b110;

  localparam int DEFAULT_HR_COMPLETE_CYCLES = 1000;

endpackage

// File: rtl/hard_reset_receiver_if.sv
// ---------------------------------------------------------------------------
// hard_reset_receiver_if
// Bundles the PHY indications, host register accesses and policy-engine
// handshake of the hard-reset receiver.
// Modports:
//   slave  - the receiver: PHY/register/PE inputs in, ALERT/status out
//   master - the environment (PHY, host, policy engine) driving it
// Signals:
//   PHY_HR_Received, PHY_CR_Received  PHY ordered-set pulses
//   iRECEIVE_DETECT[7:0], iRECEIVE_DETECT_WR  RECEIVE_DETECT write
//   iAlert_Clear[15:0]  write-1-to-clear mask for ALERT
//   PE_HR_Complete      policy engine done
//   ALERT[15:0], oRECEIVE_DETECT[7:0], oRX_BUF_FRAME_TYPE[2:0]
//   PRL_Reset, PE_HR_Indication, HR_Busy
// ---------------------------------------------------------------------------
interface hard_reset_receiver_if;

  logic        PHY_HR_Received;
  logic        PHY_CR_Received;
  logic [7:0]  iRECEIVE_DETECT;
  logic        iRECEIVE_DETECT_WR;
  logic [15:0] iAlert_Clear;
  logic        PE_HR_Complete;
  logic [15:0] ALERT;
  logic [7:0]  oRECEIVE_DETECT;
  logic [2:0]  oRX_BUF_FRAME_TYPE;
  logic        PRL_Reset;
  logic        PE_HR_Indication;
  logic        HR_Busy;

  modport slave (
    input  PHY_HR_Received, PHY_CR_Received, iRECEIVE_DETECT,
           iRECEIVE_DETECT_WR, iAlert_Clear, PE_HR_Complete,
    output ALERT, oRECEIVE_DETECT, oRX_BUF_FRAME_TYPE, PRL_Reset,
           PE_HR_Indication, HR_Busy
  );

  modport master (
    output PHY_HR_Received, PHY_CR_Received, iRECEIVE_DETECT,
           iRECEIVE_DETECT_WR, iAlert_Clear, PE_HR_Complete,
    input  ALERT, oRECEIVE_DETECT, oRX_BUF_FRAME_TYPE, PRL_Reset,
           PE_HR_Indication, HR_Busy
  );

endinterface

// File: rtl/hard_reset_receiver_timeout_counter.sv
// ---------------------------------------------------------------------------
// hr_timeout_counter
// Saturating up-counter timing the policy engine's hard-reset completion.
// Ports:
//   CLK       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   enable    in   count one step per cycle while high
//   clear     in   synchronous clear (wins over enable)
//   terminal  out  high while count == TERMINAL
// Parameters: CNT_W counter width, TERMINAL terminal-count value.
// ---------------------------------------------------------------------------
module hr_timeout_counter #(
  parameter int CNT_W    = 10,
  parameter int TERMINAL = 999
) (
  input  logic CLK,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM_VALUE = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count;

  // Holds at all-ones instead of wrapping so a stuck enable can never
  // bring the count back around to the terminal value.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERM_VALUE);

endmodule

// File: rtl/hard_reset_receiver.sv
// ---------------------------------------------------------------------------
// hard_reset_receiver
// Receive side of the TCPC hard-reset path. Detects Hard Reset / Cable Reset
// reported by the PHY (gated by RECEIVE_DETECT), pulses PRL_Reset, clears
// RECEIVE_DETECT, raises ALERT.ReceivedHardReset, then handshakes with the
// policy engine and raises ALERT.Fault if completion does not arrive within
// HR_COMPLETE_CYCLES.
// Ports:
//   CLK    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    hard_reset_receiver_if.slave (PHY, register, PE and status)
// Parameters: HR_COMPLETE_CYCLES (>= 2), CNT_W (2^CNT_W > HR_COMPLETE_CYCLES)
// Configuration macro: HR_CABLE_RESET_EN - when defined, Cable Reset is
// detected; otherwise PHY_CR_Received is ignored and RECEIVE_DETECT bit 6
// always reads 0.
// ---------------------------------------------------------------------------
module hard_reset_receiver
  import hr_pkg::*;
#(
  parameter int HR_COMPLETE_CYCLES = DEFAULT_HR_COMPLETE_CYCLES,
  parameter int CNT_W              = 10
) (
  input logic                 CLK,
  input logic                 reset,
  hard_reset_receiver_if.slave bus
);

  hr_state_t   state;
  logic [15:0] alert_q;
  logic [15:0] alert_set;
  logic [7:0]  receive_detect_q;
  logic [7:0]  rd_wr_data;
  logic [2:0]  frame_type_q;
  logic [2:0]  pending_frame;
  logic        prl_reset_q;
  logic        pe_indication_q;
  logic        busy_q;
  logic        cr_enable;
  logic        hr_hit;
  logic        cr_hit;
  logic        timeout_hit;

`ifdef HR_CABLE_RESET_EN
  assign cr_enable  = 1'b1;
  assign rd_wr_data = bus.iRECEIVE_DETECT;
`else
  assign cr_enable  = 1'b0;
  assign rd_wr_data = bus.iRECEIVE_DETECT & ~(8'(1) << RD_CABLE_RESET_EN);
`endif

  assign hr_hit = bus.PHY_HR_Received & receive_detect_q[RD_HARD_RESET_EN];
  assign cr_hit = bus.PHY_CR_Received & receive_detect_q[RD_CABLE_RESET_EN] & cr_enable;

  hr_timeout_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (HR_COMPLETE_CYCLES - 1)
  ) u_timeout (
    .CLK      (CLK),
    .reset    (reset),
    .enable   (state == WAIT_PE_COMPLETE),
    .clear    (state == INDICATE),
    .terminal (timeout_hit)
  );

  // ALERT sets are decoded from the state so the register update below can
  // apply "set wins over same-cycle clear" in a single expression.
  always_comb begin
    alert_set = '0;
    if (state == RESET_LAYER) begin
      alert_set[ALERT_RX_HARD_RESET] = 1'b1;
    end
    if ((state == WAIT_PE_COMPLETE) && !bus.PE_HR_Complete && timeout_hit) begin
      alert_set[ALERT_FAULT] = 1'b1;
    end
  end

  // Main FSM. Each state's outputs are loaded on the edge that enters it,
  // so they are visible for exactly the cycle(s) spent in that state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state            <= WAIT_FOR_HR;
      alert_q          <= '0;
      receive_detect_q <= '0;
      frame_type_q     <= FRAME_NONE;
      pending_frame    <= FRAME_NONE;
      prl_reset_q      <= 1'b0;
      pe_indication_q  <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      alert_q     <= ((alert_q & ~bus.iAlert_Clear) | alert_set) & ALERT_USED_MASK;
      prl_reset_q <= 1'b0;
      case (state)
        WAIT_FOR_HR: begin
          // A hit is judged on the old register value; a write in the same
          // cycle as a hit is dropped.
          if (hr_hit || cr_hit) begin
            state         <= RESET_LAYER;
            prl_reset_q   <= 1'b1;
            busy_q        <= 1'b1;
            pending_frame <= hr_hit ? FRAME_HARD_RESET : FRAME_CABLE_RESET;
          end else if (bus.iRECEIVE_DETECT_WR) begin
            receive_detect_q <= rd_wr_data;
          end
        end
        RESET_LAYER: begin
          state            <= INDICATE;
          receive_detect_q <= '0;
          frame_type_q     <= pending_frame;
          pe_indication_q  <= 1'b1;
        end
        INDICATE: begin
          state <= WAIT_PE_COMPLETE;
        end
        WAIT_PE_COMPLETE: begin
          if (bus.PE_HR_Complete) begin
            state           <= REPORT;
            pe_indication_q <= 1'b0;
            frame_type_q    <= FRAME_NONE;
          end else if (timeout_hit) begin
            state <= TIMEOUT;
          end
        end
        TIMEOUT: begin
          state           <= REPORT;
          pe_indication_q <= 1'b0;
          frame_type_q    <= FRAME_NONE;
        end
        REPORT: begin
          state  <= WAIT_FOR_HR;
          busy_q <= 1'b0;
        end
        default: begin
          state           <= WAIT_FOR_HR;
          busy_q          <= 1'b0;
          pe_indication_q <= 1'b0;
          frame_type_q    <= FRAME_NONE;
        end
      endcase
    end
  end

  assign bus.ALERT              = alert_q;
  assign bus.oRECEIVE_DETECT    = receive_detect_q;
  assign bus.oRX_BUF_FRAME_TYPE = frame_type_q;
  assign bus.PRL_Reset          = prl_reset_q;
  assign bus.PE_HR_Indication   = pe_indication_q;
  assign bus.HR_Busy            = busy_q;

endmodule

// File: tb/tb_hard_reset_receiver.sv
// ---------------------------------------------------------------------------
// tb_hard_reset_receiver
// Directed bench for hard_reset_receiver (HR_COMPLETE_CYCLES=8, CNT_W=4).
// Every change of the DUT's output vector is an observed event; the stimulus
// pushes the expected vector and the cycle it must appear in, and a monitor
// on the falling edge pops and compares each event in order.
// Output vector = {ALERT, oRECEIVE_DETECT, oRX_BUF_FRAME_TYPE, PRL_Reset,
//                  PE_HR_Indication, HR_Busy}.
// Expectations follow HR_CABLE_RESET_EN the same way the DUT build does.
// ---------------------------------------------------------------------------
module tb_hard_reset_receiver;

  typedef struct {
    int          cyc;
    logic [29:0] vec;
    string       tag;
  } exp_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [29:0] prev_vec;
  logic [29:0] cur_vec;

  logic [15:0] exp_alert = '0;
  logic [7:0]  exp_rd = '0;
  logic [2:0]  exp_frame = '0;
  logic        exp_prl = 1'b0;
  logic        exp_ind = 1'b0;
  logic        exp_busy = 1'b0;

  hard_reset_receiver_if hr_bus ();

  hard_reset_receiver #(
    .HR_COMPLETE_CYCLES (8),
    .CNT_W              (4)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (hr_bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [29:0] dut_vec();
    return {hr_bus.ALERT, hr_bus.oRECEIVE_DETECT, hr_bus.oRX_BUF_FRAME_TYPE,
            hr_bus.PRL_Reset, hr_bus.PE_HR_Indication, hr_bus.HR_Busy};
  endfunction

  function automatic logic [29:0] model_vec();
    return {exp_alert, exp_rd, exp_frame, exp_prl, exp_ind, exp_busy};
  endfunction

  task automatic check_output(input string name, input logic [29:0] act,
                              input logic [29:0] expv, input int act_cyc,
                              input int exp_cyc);
    checks++;
    if (act !== expv || act_cyc != exp_cyc) begin
      failures++;
      $display("[TB] FAIL %s: got vec=%h at cycle %0d, expected vec=%h at cycle %0d",
               name, act, act_cyc, expv, exp_cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one cycle's worth of inputs; afterwards cyc is that cycle.
  task automatic apply_stimulus(input logic hr, input logic cr, input logic wr,
                                input logic [7:0] wdata, input logic [15:0] clr,
                                input logic pe);
    tick();
    hr_bus.PHY_HR_Received    = hr;
    hr_bus.PHY_CR_Received    = cr;
    hr_bus.iRECEIVE_DETECT_WR = wr;
    hr_bus.iRECEIVE_DETECT    = wdata;
    hr_bus.iAlert_Clear       = clr;
    hr_bus.PE_HR_Complete     = pe;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  task automatic expect_at(input int c, input string tag);
    exp_t e;
    e.cyc = c;
    e.vec = model_vec();
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic write_rd(input logic [7:0] val, input string tag);
    logic [7:0] masked;
    apply_stimulus(1'b0, 1'b0, 1'b1, val, 16'h0000, 1'b0);
    masked = val;
`ifndef HR_CABLE_RESET_EN
    masked[6] = 1'b0;
`endif
    if (masked != exp_rd) begin
      exp_rd = masked;
      expect_at(cyc + 1, tag);
    end
    idle(1);
  endtask

  task automatic expect_detect(input int n, input logic [2:0] frame, input string tag);
    exp_prl  = 1'b1;
    exp_busy = 1'b1;
    expect_at(n + 1, {tag, "_prl_reset"});
    exp_prl   = 1'b0;
    exp_alert = exp_alert | 16'h0008;
    exp_ind   = 1'b1;
    exp_rd    = 8'h00;
    exp_frame = frame;
    expect_at(n + 2, {tag, "_indicate"});
  endtask

  task automatic expect_report(input int r, input string tag);
    exp_ind   = 1'b0;
    exp_frame = 3'b000;
    expect_at(r, {tag, "_report"});
    exp_busy = 1'b0;
    expect_at(r + 1, {tag, "_idle"});
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      cur_vec = dut_vec();
      if (cur_vec !== prev_vec) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got vec=%h at cycle %0d, expected no change",
                   cur_vec, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output(mon_e.tag, cur_vec, mon_e.vec, cyc, mon_e.cyc);
        end
        prev_vec = cur_vec;
      end
    end
  end

  initial begin
    int n;
    int guard;
    hr_bus.PHY_HR_Received    = 1'b0;
    hr_bus.PHY_CR_Received    = 1'b0;
    hr_bus.iRECEIVE_DETECT_WR = 1'b0;
    hr_bus.iRECEIVE_DETECT    = 8'h00;
    hr_bus.iAlert_Clear       = 16'h0000;
    hr_bus.PE_HR_Complete     = 1'b0;
    prev_vec = '0;

    repeat (3) tick();
    check_output("reset_state", dut_vec(), 30'h0, cyc, cyc);
    tick();
    reset  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Hard Reset with no completion: timeout path.
    write_rd(8'h20, "t1_rd_write");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    n = cyc;
    expect_detect(n, 3'b101, "t1");
    exp_alert = exp_alert | 16'h0200;
    expect_at(n + 11, "t1_timeout_fault");
    expect_report(n + 12, "t1");
    idle(14);

    // Clear both alert bits.
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0208, 1'b0);
    exp_alert = 16'h0000;
    expect_at(cyc + 1, "t2_alert_clear");
    idle(1);

    // Clear coinciding with set, then clear a cycle later; PE completes.
    write_rd(8'h20, "t3_rd_write");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    n = cyc;
    expect_detect(n, 3'b101, "t3");
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0008, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0008, 1'b0);
    exp_alert = 16'h0000;
    expect_at(n + 3, "t3_clear_after_set");
    idle(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    expect_report(n + 5, "t3");
    idle(3);

    // Completion on the terminal-count cycle beats the timeout; a PHY pulse
    // mid-sequence is ignored.
    write_rd(8'h20, "t4_rd_write");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    n = cyc;
    expect_detect(n, 3'b101, "t4");
    idle(4);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    idle(4);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    expect_report(n + 11, "t4");
    idle(3);

    // Simultaneous HR and CR: Hard Reset wins.
    write_rd(8'h60, "t5_rd_write");
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    n = cyc;
    expect_detect(n, 3'b101, "t5");
    idle(2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    expect_report(n + 4, "t5");
    idle(3);

    // Cable Reset only: detected only when the feature is built in.
    write_rd(8'h60, "t6_rd_write");
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    n = cyc;
`ifdef HR_CABLE_RESET_EN
    expect_detect(n, 3'b110, "t6");
    expect_report(n + 4, "t6");
`endif
    idle(2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    idle(3);

    // Detection disabled: HR pulse produces nothing.
    write_rd(8'h00, "t7_rd_write");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    idle(5);

    // Write with no hit loads; write with a hit is judged on the old value
    // and discarded.
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h20, 16'h0000, 1'b0);
    exp_rd = 8'h20;
    expect_at(cyc + 1, "t8_write_no_hit");
    idle(1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0);
    n = cyc;
    expect_detect(n, 3'b101, "t8");
    idle(3);

    // Reset mid WAIT_PE_COMPLETE: outputs clear immediately.
    exp_alert = '0; exp_rd = '0; exp_frame = '0;
    exp_prl = 1'b0; exp_ind = 1'b0; exp_busy = 1'b0;
    expect_at(n + 4, "t9_reset_mid_sequence");
    tick();
    reset = 1'b0;
    #1;
    check_output("t9_reset_async", dut_vec(), 30'h0, cyc, n + 4);
    tick();
    tick();
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    idle(3);
    write_rd(8'h20, "t9_rd_rewrite");
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    n = cyc;
    expect_detect(n, 3'b101, "t9");
    idle(2);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    expect_report(n + 4, "t9");
    idle(3);

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check_output("scoreboard_drain", 30'(exp_q.size()), 30'h0, cyc, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hard_reset_receiver.md
Name: hard_reset_receiver

Overview:
Receive-side counterpart of the hard-reset transmit path in the USB-PD TCPC protocol layer. Detects Hard Reset or Cable Reset signalling reported by the PHY, gated by RECEIVE_DETECT enables. On detection it resets the protocol layer, clears RECEIVE_DETECT and raises ALERT.ReceivedHardReset. It then handshakes with the policy engine and flags a fault if the policy engine does not complete within a bounded time.

Parameters:
HR_COMPLETE_CYCLES, 1000, CLK cycles allowed for PE_HR_Complete after indication (must be >= 2)
CNT_W, 10, timeout counter width; must satisfy 2^CNT_W > HR_COMPLETE_CYCLES

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
PHY_HR_Received  in  1  one-cycle pulse: PHY decoded Hard Reset ordered set
PHY_CR_Received  in  1  one-cycle pulse: PHY decoded Cable Reset ordered set
iRECEIVE_DETECT  in  8  register write data; bit5 = HR enable, bit6 = CR enable
iRECEIVE_DETECT_WR  in  1  write strobe for iRECEIVE_DETECT
iAlert_Clear  in  16  write-1-to-clear mask for ALERT, one cycle
PE_HR_Complete  in  1  policy engine finished hard-reset processing, pulse or level
ALERT  out  16  alert register; bit3 ReceivedHardReset, bit9 Fault (PE timeout)
oRECEIVE_DETECT  out  8  live RECEIVE_DETECT register
oRX_BUF_FRAME_TYPE  out  3  3'b101 Hard Reset, 3'b110 Cable Reset, 3'b000 none
PRL_Reset  out  1  one-cycle pulse resetting protocol-layer TX/RX
PE_HR_Indication  out  1  level to policy engine; high while awaiting completion
HR_Busy  out  1  high in every state except WAIT_FOR_HR

Behaviour:
- Reset (async, reset=0): state = WAIT_FOR_HR; all outputs 0; counter 0.
- Interface: one clock (CLK); asynchronous, active-low reset (reset). All outputs are registered.
- States (one-hot): WAIT_FOR_HR, RESET_LAYER, INDICATE, WAIT_PE_COMPLETE, TIMEOUT, REPORT.
- WAIT_FOR_HR:
  - iRECEIVE_DETECT_WR loads oRECEIVE_DETECT in this state only; ignored in all other states.
  - hr_hit = PHY_HR_Received & oRECEIVE_DETECT[5]; cr_hit = PHY_CR_Received & oRECEIVE_DETECT[6].
  - Either hit: latch the frame type and go to RESET_LAYER. If both hit in the same cycle, Hard Reset wins (3'b101).
  - Same-cycle write strobe and hit: the hit is evaluated against the old oRECEIVE_DETECT; the write is discarded.
- RESET_LAYER (1 cycle): PRL_Reset=1; oRECEIVE_DETECT <= 0; oRX_BUF_FRAME_TYPE <= latched type; next INDICATE.
- INDICATE (1 cycle): ALERT[3] <= 1; PE_HR_Indication <= 1; counter <= 0; next WAIT_PE_COMPLETE.
- WAIT_PE_COMPLETE: counter increments each cycle.
  - PE_HR_Complete=1: go to REPORT. Completion is checked first, so it wins over a same-cycle timeout.
  - Counter == HR_COMPLETE_CYCLES-1 without completion: go to TIMEOUT.
- TIMEOUT (1 cycle): ALERT[9] <= 1; next REPORT.
- REPORT (1 cycle): PE_HR_Indication <= 0; oRX_BUF_FRAME_TYPE <= 0; next WAIT_FOR_HR.
- Detection latency: hit cycle N -> PRL_Reset at N+1 -> ALERT[3] and PE_HR_Indication at N+2.
- ALERT clearing: ALERT <= (ALERT & ~iAlert_Clear) | set_bits in every state. A set wins over a same-cycle clear. Bits other than 3 and 9 are held at 0.
- PHY pulses arriving in any state other than WAIT_FOR_HR are ignored. RECEIVE_DETECT is already 0 at that point, so a new reception requires the host to rewrite it.
- Reset asserted mid-sequence: immediate return to reset values. PE_HR_Indication drops asynchronously.
- Counter saturates; it never wraps.

Optional Feature:
HR_CABLE_RESET_EN
- Defined: Cable Reset detection as specified above.
- Undefined: PHY_CR_Received is ignored, oRECEIVE_DETECT[6] is always written 0, and the 3'b110 frame type is never produced.

Decomposition:
- Package hr_pkg: state one-hot localparams; ALERT bit indices (ALERT_RX_HARD_RESET=3, ALERT_FAULT=9); RECEIVE_DETECT bit indices (5, 6); frame-type codes (3'b101, 3'b110); default HR_COMPLETE_CYCLES.
- One sub-module: hr_timeout_counter (enable, clear, terminal-count flag, CNT_W wide, saturating).

Test Plan:
- oRECEIVE_DETECT=8'h20, PHY_HR_Received pulse at cycle N -> PRL_Reset at N+1, ALERT=16'h0008 and PE_HR_Indication=1 at N+2, oRECEIVE_DETECT=0, oRX_BUF_FRAME_TYPE=3'b101.
- oRECEIVE_DETECT=8'h60, HR and CR pulses in the same cycle -> frame type 3'b101. With HR_CABLE_RESET_EN defined and a CR-only pulse -> 3'b110. With the macro undefined, a CR-only pulse -> no response.
- oRECEIVE_DETECT=8'h00, HR pulse -> no state change, ALERT stays 0.
- HR_COMPLETE_CYCLES=8, PE_HR_Complete never asserted -> ALERT=16'h0208 eight cycles after INDICATE, then PE_HR_Indication=0.
- iAlert_Clear=16'h0008 in the same cycle ALERT[3] is set -> ALERT[3]=1. A clear one cycle later -> ALERT[3]=0.
- reset=0 asserted during WAIT_PE_COMPLETE -> all outputs 0 immediately. After release, a new HR is detected only after iRECEIVE_DETECT is rewritten.
